// File: rtl/mips_pkg.sv
// Shared types and defaults for the MIPS instruction-fetch front end.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc_incr;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam int unsigned DEFAULT_DEPTH    = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Small circular queue of fetched {PC+4, instruction} entries with a combinational head.
module fetch_fifo
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  fetch_entry_t             push_data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output fetch_entry_t             head_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Push while full is safe when paired with a pop: the write slot is the one being freed.
         if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ack handshake, and queues
// fetched words towards IF/ID. Redirects flush the queue and discard any stale fetch.
module if_fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH    = DEFAULT_DEPTH,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc_incr,
   output logic [31:0] fetch_pc
);

   localparam int unsigned CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   addr_q, addr_d;
   logic          req_q, req_d;
   logic [CW-1:0] count;
   logic [CW:0]   count_next;
   logic          ack_seen, push, pop, space;
   logic [31:0]   pc_plus4, redirect_tgt;
   fetch_entry_t  push_entry, head;

   assign pc_plus4     = fetch_pc_q + 32'd4;
   assign redirect_tgt = {redirect_pc[31:2], 2'b00};
   assign ack_seen     = imem_ack & req_q;
   assign push         = (state_q == WAIT) & ack_seen & ~redirect;
   assign id_valid     = (count != '0) & ~redirect;
   assign pop          = id_valid & id_ready;
   assign count_next   = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
   // Issue only if a word returning later still has a free slot: count_next + 1 <= DEPTH.
   assign space        = count_next < DEPTH_W;
   assign push_entry   = '{pc_incr: pc_plus4, instr: imem_rdata};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               fetch_pc_d = redirect_tgt;
            end else if (space) begin
               state_d = WAIT;
               addr_d  = fetch_pc_q;
            end
         end
         WAIT: begin
            if (redirect) begin
               fetch_pc_d = redirect_tgt;
               state_d    = ack_seen ? IDLE : DROP;
            end else if (ack_seen) begin
               fetch_pc_d = pc_plus4;
               if (space) addr_d  = pc_plus4;
               else       state_d = IDLE;
            end
         end
         DROP: begin
            if (redirect) fetch_pc_d = redirect_tgt;
            if (ack_seen) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      req_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect),
      .count_o     (count),
      .head_o      (head)
   );

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign id_instr   = head.instr;
   assign id_pc_incr = head.pc_incr;
   assign fetch_pc   = fetch_pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory responder, stream-order model, directed and random runs.
module tb_if_fetch_unit;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_ready = 1'b0;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc_incr;
   logic [31:0] fetch_pc;

   always #5 clk = ~clk;

   if_fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_ready    (id_ready),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc_incr  (id_pc_incr),
      .fetch_pc    (fetch_pc)
   );

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", name);
   endtask

   // Memory: request seen at posedge+2; ack after mem_wait (or random) wait cycles.
   int unsigned mem_wait = 0;
   bit          mem_rand = 1'b0;
   bit          late_ack = 1'b0;
   bit          busy = 1'b0;
   int unsigned cnt = 0;
   logic [31:0] cur = '0;

   always begin
      @(posedge clk);
      #2;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      if (late_ack) begin
         imem_ack   = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
      end else if (rst || !imem_req) begin
         busy = 1'b0;
      end else begin
         if (!busy) begin
            busy = 1'b1;
            cur  = imem_addr;
            cnt  = mem_rand ? $urandom_range(0, 3) : mem_wait;
         end else begin
            check32("imem_addr_stable", imem_addr, cur);
         end
         if (cnt == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = word_at(cur);
            busy       = 1'b0;
         end else begin
            cnt--;
         end
      end
   end

   // Architectural stream model: deliveries are consecutive words starting at the last reset/redirect target.
   logic [31:0] exp_pc = '0;
   int          delivered = 0;

   always @(negedge clk) begin
      if (rst) begin
         exp_pc = RESET_PC;
      end else if (redirect) begin
         check1("no_handshake_on_redirect", id_valid, 1'b0);
         exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (id_valid && id_ready) begin
         check32("stream_pc_incr", id_pc_incr, exp_pc + 32'd4);
         check32("stream_instr", id_instr, word_at(exp_pc));
         exp_pc = exp_pc + 32'd4;
         delivered++;
      end
   end

   task automatic check_reset_vals(input string tag);
      check1({tag, "_imem_req"}, imem_req, 1'b0);
      check32({tag, "_imem_addr"}, imem_addr, RESET_PC);
      check1({tag, "_id_valid"}, id_valid, 1'b0);
      check32({tag, "_id_instr"}, id_instr, 32'h0);
      check32({tag, "_id_pc_incr"}, id_pc_incr, 32'h0);
      check32({tag, "_fetch_pc"}, fetch_pc, RESET_PC);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = '0;
      id_ready    = 1'b0;
      late_ack    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      bit          ready;
      bit          e_req;
      logic [31:0] e_addr;
      bit          e_valid;
      logic [31:0] e_incr;
      logic [31:0] e_fpc;
   } vec_t;

   vec_t vt[4];
   bit   ok;
   int   d0;

   initial begin
      // Zero-wait streaming after reset: addresses 0,4,8,12 back to back, no bubbles.
      vt[0] = '{ready: 1'b1, e_req: 1'b1, e_addr: 32'h0, e_valid: 1'b0, e_incr: 32'h0, e_fpc: 32'h0};
      vt[1] = '{ready: 1'b1, e_req: 1'b1, e_addr: 32'h4, e_valid: 1'b1, e_incr: 32'h4, e_fpc: 32'h4};
      vt[2] = '{ready: 1'b1, e_req: 1'b1, e_addr: 32'h8, e_valid: 1'b1, e_incr: 32'h8, e_fpc: 32'h8};
      vt[3] = '{ready: 1'b1, e_req: 1'b1, e_addr: 32'hC, e_valid: 1'b1, e_incr: 32'hC, e_fpc: 32'hC};

      mem_rand = 1'b0;
      mem_wait = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 id_ready = vt[i].ready;
         @(negedge clk);
         check1("tbl_req", imem_req, vt[i].e_req);
         check32("tbl_addr", imem_addr, vt[i].e_addr);
         check1("tbl_valid", id_valid, vt[i].e_valid);
         check32("tbl_fetch_pc", fetch_pc, vt[i].e_fpc);
         if (vt[i].e_valid) begin
            check32("tbl_pc_incr", id_pc_incr, vt[i].e_incr);
            check32("tbl_instr", id_instr, word_at(vt[i].e_incr - 32'd4));
         end
      end

      // Back-pressure: queue fills to DEPTH, request drops, drain resumes fetch at 0x10.
      do_reset();
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check1("full_req_low", imem_req, 1'b0);
      check1("full_valid", id_valid, 1'b1);
      check32("full_head", id_pc_incr, 32'h4);
      check32("full_fetch_pc", fetch_pc, 32'h10);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1 id_ready = 1'b1;
         @(negedge clk);
         check1("drain_valid", id_valid, 1'b1);
         check32("drain_pc_incr", id_pc_incr, 32'(4 * (i + 1)));
         if (i == 1) begin
            check1("resume_req", imem_req, 1'b1);
            check32("resume_addr", imem_addr, 32'h10);
         end
      end

      // Slow memory, redirect (unaligned target) while the fetch is outstanding.
      mem_wait = 2;
      do_reset();
      @(posedge clk);
      #1 id_ready = 1'b1;
      @(negedge clk);
      check1("slow_req", imem_req, 1'b1);
      @(posedge clk);
      #1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0103;
      @(negedge clk);
      @(posedge clk);
      #1 redirect = 1'b0;
      @(negedge clk);
      check1("drop_req_held", imem_req, 1'b1);
      check32("drop_addr_held", imem_addr, 32'h0);
      check32("drop_fetch_pc", fetch_pc, 32'h100);
      check1("drop_valid", id_valid, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check1("drop_idle_req", imem_req, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (imem_req) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("redir_req_wait");
      else     check32("redir_req_addr", imem_addr, 32'h100);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (id_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("redir_valid_wait");
      else     check32("redir_first_incr", id_pc_incr, 32'h104);

      // Redirect coincident with ack and a non-empty queue.
      mem_wait = 0;
      do_reset();
      repeat (2) begin
         @(posedge clk);
         #1 id_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      @(negedge clk);
      check1("coinc_no_valid", id_valid, 1'b0);
      @(posedge clk);
      #1 redirect = 1'b0;
      @(negedge clk);
      check1("coinc_flushed", id_valid, 1'b0);
      check1("coinc_idle", imem_req, 1'b0);
      check32("coinc_fetch_pc", fetch_pc, 32'h200);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (id_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("coinc_valid_wait");
      else     check32("coinc_first_incr", id_pc_incr, 32'h204);

      // PC+4 wrap at the top of the address space.
      @(posedge clk);
      #1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFF;
      @(negedge clk);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 redirect = 1'b0;
         @(negedge clk);
         if (id_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("wrap_valid_wait");
      else begin
         check32("wrap_incr", id_pc_incr, 32'h0);
         check32("wrap_next_addr", imem_addr, 32'h0);
         check32("wrap_fetch_pc", fetch_pc, 32'h0);
      end

      // Asynchronous reset in WAIT with two entries queued; late ack afterwards must be ignored.
      mem_wait = 1;
      do_reset();
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check1("pre_rst_req", imem_req, 1'b1);
      check32("pre_rst_addr", imem_addr, 32'h8);
      check32("pre_rst_head", id_pc_incr, 32'h4);
      #2 rst = 1'b1;
      #1 check_reset_vals("async_rst");
      mem_wait = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      late_ack = 1'b1;
      id_ready = 1'b1;
      @(posedge clk);
      #1 late_ack = 1'b0;
      @(negedge clk);
      check1("post_rst_req", imem_req, 1'b1);
      check32("post_rst_addr", imem_addr, RESET_PC);
      check1("post_rst_valid", id_valid, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (id_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) timeout_fail("post_rst_valid_wait");
      else     check32("post_rst_first_instr", id_instr, word_at(RESET_PC));

      // Random traffic: variable latency, back-pressure and redirects against the stream model.
      mem_rand = 1'b1;
      do_reset();
      d0 = delivered;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         id_ready    = ($urandom_range(0, 3) != 0);
         redirect    = ($urandom_range(0, 31) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom();
      end
      @(posedge clk);
      #1 redirect = 1'b0;
      repeat (5) @(posedge clk);
      checks++;
      if (delivered - d0 < 200) begin
         errors++;
         $display("FAIL random_progress actual=%0d required=>=200", delivered - d0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
